// File: rtl/cog_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cog_divider
// Purpose  : Buffers per-figure centre-of-gravity sums and line/frame markers
//            in a small FIFO, divides sum(I^2*x) by sum(I^2) with a serial
//            restoring divider and emits one beat per buffered entry as an
//            absolute unsigned 12.4 coordinate.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_sys_clk              in   1  clock, all logic on the rising edge
//   i_sys_aresetn          in   1  asynchronous active-low reset
//   i_sum_of_I_mult_coord  in  30  sum of I^2 * relative coordinate
//   i_sum_of_I             in  23  sum of I^2
//   i_start_point          in  11  absolute coordinate of first pixel
//   i_point_is_valid       in   1  sums/start valid strobe
//   i_end_of_line          in   1  marker, aligned with the point strobe
//   i_end_of_frame         in   1  marker, aligned with the point strobe
//   i_new_frame            in   1  marker, aligned with the point strobe
//   i_ready                in   1  downstream accepts the current beat
//   o_point                out 16  CoG coordinate, unsigned 12.4
//   o_point_valid          out  1  o_point carries a result
//   o_end_of_line          out  1  marker carried in this beat
//   o_end_of_frame         out  1  marker carried in this beat
//   o_new_frame            out  1  marker carried in this beat
//   o_valid                out  1  beat present
//   o_overflow             out  1  sticky: an input entry was lost
// ============================================================================
module cog_divider #(
  parameter int FIFO_DEPTH = 16,
  parameter int FRAC_BITS  = 4
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_aresetn,
  input  logic [29:0] i_sum_of_I_mult_coord,
  input  logic [22:0] i_sum_of_I,
  input  logic [10:0] i_start_point,
  input  logic        i_point_is_valid,
  input  logic        i_end_of_line,
  input  logic        i_end_of_frame,
  input  logic        i_new_frame,
  input  logic        i_ready,
  output logic [15:0] o_point,
  output logic        o_point_valid,
  output logic        o_end_of_line,
  output logic        o_end_of_frame,
  output logic        o_new_frame,
  output logic        o_valid,
  output logic        o_overflow
);

  localparam int c_aw    = $clog2(FIFO_DEPTH);
  localparam int c_dvd_w = 30 + FRAC_BITS;
  localparam int c_cnt_w = $clog2(c_dvd_w);

  localparam logic [c_aw-1:0]    c_ptr_one   = c_aw'(1);
  localparam logic [c_aw:0]      c_cnt_one   = (c_aw+1)'(1);
  localparam logic [c_aw:0]      c_depth     = (c_aw+1)'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(c_dvd_w - 1);
  localparam logic [c_cnt_w-1:0] c_step_one  = c_cnt_w'(1);

  typedef struct packed {
    logic        pt;
    logic        eol;
    logic        eof;
    logic        nf;
    logic [29:0] mult;
    logic [22:0] sum;
    logic [10:0] start;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input FIFO
  // --------------------------------------------------------------------------
  entry_t          r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            r_overflow;

  entry_t w_wr_entry;
  entry_t w_head;
  logic   w_push_req;
  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;

  assign w_wr_entry = '{pt:    i_point_is_valid,
                        eol:   i_end_of_line,
                        eof:   i_end_of_frame,
                        nf:    i_new_frame,
                        mult:  i_sum_of_I_mult_coord,
                        sum:   i_sum_of_I,
                        start: i_start_point};

  assign w_push_req = i_point_is_valid | i_end_of_line | i_end_of_frame | i_new_frame;
  assign w_full     = (r_count == c_depth);
  assign w_empty    = (r_count == '0);
  // A full FIFO still takes the write when the head leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge i_sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      // A stored new-frame entry wins over a loss in the same cycle.
      if (w_push && i_new_frame) begin
        r_overflow <= 1'b0;
      end else if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_next_state;
  logic [c_cnt_w-1:0]  r_cnt;

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = (w_head.pt && (w_head.sum != '0)) ? DIV : OUT;
        end
      end
      DIV: begin
        if (r_cnt == c_last_step) begin
          w_next_state = OUT;
        end
      end
      OUT: begin
        if (i_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Serial restoring divider. Dividend and quotient share r_dq: the dividend
  // shifts out of the top while quotient bits shift in at the bottom, so after
  // the last step r_dq holds the full quotient.
  // --------------------------------------------------------------------------
  logic [c_dvd_w-1:0] r_dq;
  logic [22:0]        r_rem;
  logic [22:0]        r_divisor;
  logic [10:0]        r_start;
  logic               r_pt_valid;
  logic               r_eol;
  logic               r_eof;
  logic               r_nf;
  logic [15:0]        r_point;

  logic [23:0]        w_rem_shift;
  logic               w_ge;
  logic [22:0]        w_rem_next;
  logic [c_dvd_w-1:0] w_dq_next;
  logic [14:0]        w_q_sat;
  logic [15:0]        w_point_sum;

  assign w_rem_shift = {r_rem, r_dq[c_dvd_w-1]};
  // The partial remainder stays below the divisor, so a set top bit of the
  // shifted value always means "subtract" and the low-bit difference is exact.
  assign w_ge        = w_rem_shift[23] | (w_rem_shift[22:0] >= r_divisor);
  assign w_rem_next  = w_ge ? (w_rem_shift[22:0] - r_divisor) : w_rem_shift[22:0];
  assign w_dq_next   = {r_dq[c_dvd_w-2:0], w_ge};
  assign w_q_sat     = (|w_dq_next[c_dvd_w-1:15]) ? 15'h7FFF : w_dq_next[14:0];
  assign w_point_sum = {1'b0, r_start, {FRAC_BITS{1'b0}}} + {1'b0, w_q_sat};

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_dq       <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_start    <= '0;
      r_cnt      <= '0;
      r_pt_valid <= 1'b0;
      r_eol      <= 1'b0;
      r_eof      <= 1'b0;
      r_nf       <= 1'b0;
      r_point    <= '0;
    end else if (w_pop) begin
      r_dq       <= {w_head.mult, {FRAC_BITS{1'b0}}};
      r_rem      <= '0;
      r_divisor  <= w_head.sum;
      r_start    <= w_head.start;
      r_cnt      <= '0;
      r_pt_valid <= w_head.pt && (w_head.sum != '0);
      r_eol      <= w_head.eol;
      r_eof      <= w_head.eof;
      r_nf       <= w_head.nf;
      r_point    <= '0;
    end else if (r_state == DIV) begin
      r_dq  <= w_dq_next;
      r_rem <= w_rem_next;
      r_cnt <= r_cnt + c_step_one;
      if (r_cnt == c_last_step) begin
        r_point <= w_point_sum;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: only meaningful in OUT, forced to zero elsewhere.
  // --------------------------------------------------------------------------
  logic w_out;
  assign w_out          = (r_state == OUT);
  assign o_valid        = w_out;
  assign o_point        = w_out ? r_point : '0;
  assign o_point_valid  = w_out & r_pt_valid;
  assign o_end_of_line  = w_out & r_eol;
  assign o_end_of_frame = w_out & r_eof;
  assign o_new_frame    = w_out & r_nf;
  assign o_overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cog_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cog_divider
// Purpose  : Directed self-checking bench for cog_divider with an arithmetic
//            reference model and an in-order expected-beat queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cog_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] sum_mult = '0;
  logic [22:0] sum_i = '0;
  logic [10:0] start_pt = '0;
  logic        pt_valid = 1'b0, eol = 1'b0, eof = 1'b0, nf = 1'b0;
  logic        ready = 1'b1;

  logic [15:0] o_point;
  logic        o_point_valid, o_eol, o_eof, o_nf, o_valid, o_overflow;

  always #5 clk = ~clk;

  cog_divider #(.FIFO_DEPTH(16), .FRAC_BITS(4)) dut (
    .i_sys_clk             (clk),
    .i_sys_aresetn         (rst_n),
    .i_sum_of_I_mult_coord (sum_mult),
    .i_sum_of_I            (sum_i),
    .i_start_point         (start_pt),
    .i_point_is_valid      (pt_valid),
    .i_end_of_line         (eol),
    .i_end_of_frame        (eof),
    .i_new_frame           (nf),
    .i_ready               (ready),
    .o_point               (o_point),
    .o_point_valid         (o_point_valid),
    .o_end_of_line         (o_eol),
    .o_end_of_frame        (o_eof),
    .o_new_frame           (o_nf),
    .o_valid               (o_valid),
    .o_overflow            (o_overflow)
  );

  typedef struct packed {
    logic        pv;
    logic [15:0] pt;
    logic        eol;
    logic        eof;
    logic        nf;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_beats  = 0;
  logic  prev_xfer = 1'b0;

  // Reference: absolute coordinate = start*16 + min(floor(mult*16/sum), 32767).
  function automatic logic [15:0] model_point(input logic [29:0] m, input logic [22:0] s,
                                              input logic [10:0] st);
    longint q;
    q = (longint'(m) * 16) / longint'(s);
    if (q > 32767) q = 32767;
    return 16'(int'(st) * 16 + int'(q));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic zero_inputs();
    sum_mult = '0; sum_i = '0; start_pt = '0;
    pt_valid = 1'b0; eol = 1'b0; eof = 1'b0; nf = 1'b0;
  endtask

  // One input cycle; optionally queue the beat the entry must produce.
  task automatic drive(input logic [29:0] m, input logic [22:0] s, input logic [10:0] st,
                       input logic pv, input logic e_l, input logic e_f, input logic n_f,
                       input logic keep);
    beat_t b;
    @(posedge clk); #1;
    sum_mult = m; sum_i = s; start_pt = st;
    pt_valid = pv; eol = e_l; eof = e_f; nf = n_f;
    if (keep) begin
      b.pv  = pv && (s != 0);
      b.pt  = b.pv ? model_point(m, s, st) : 16'd0;
      b.eol = e_l; b.eof = e_f; b.nf = n_f;
      exp_q.push_back(b);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    zero_inputs();
  endtask

  // Call right after drive(): cycle 0 is the cycle the entry is presented.
  task automatic measure_latency(output int cyc);
    cyc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_valid) begin
        cyc = k;
        break;
      end
      if (k == 0) begin
        @(posedge clk); #1;
        zero_inputs();
      end
    end
  endtask

  task automatic wait_valid(input int budget, output logic found);
    found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (o_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard: every cycle a beat is present it must match the queue head.
  always @(negedge clk) begin
    beat_t act;
    if (!rst_n) begin
      prev_xfer = 1'b0;
    end else begin
      if (prev_xfer) begin
        n_checks++;
        if (o_valid) begin
          n_errors++;
          $display("FAIL valid_drop: o_valid=1 expected 0 after transfer");
        end
      end
      prev_xfer = 1'b0;
      if (o_valid) begin
        n_checks++;
        act = '{pv: o_point_valid, pt: o_point, eol: o_eol, eof: o_eof, nf: o_nf};
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_beat: got pv=%0d pt=0x%0h m=%b expected none",
                   act.pv, act.pt, {act.eol, act.eof, act.nf});
        end else if (act !== exp_q[0]) begin
          n_errors++;
          $display("FAIL beat: got pv=%0d pt=0x%0h m=%b expected pv=%0d pt=0x%0h m=%b",
                   act.pv, act.pt, {act.eol, act.eof, act.nf},
                   exp_q[0].pv, exp_q[0].pt, {exp_q[0].eol, exp_q[0].eof, exp_q[0].nf});
        end
        if (ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          prev_xfer = 1'b1;
          n_beats++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   b0;
    int   cnt;
    logic found;

    zero_inputs();
    ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_point", o_point, 0);
    check("rst_pv", o_point_valid, 0);
    check("rst_markers", {o_eol, o_eof, o_nf}, 0);
    check("rst_ovf", o_overflow, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Divided point: 300*16/100 = 48, 50*16 + 48 = 848
    drive(300, 100, 50, 1, 0, 0, 0, 1);
    measure_latency(lat);
    check("lat_div", lat, 36);
    check("pt_848", o_point, 16'd848);
    check("pv_848", o_point_valid, 1);
    wait_drain(10);

    // Zero sum with end-of-line marker
    drive(1234, 0, 10, 1, 1, 0, 0, 1);
    measure_latency(lat);
    check("lat_zero", lat, 2);
    check("pt_zero", o_point, 0);
    check("pv_zero", o_point_valid, 0);
    check("eol_zero", o_eol, 1);
    wait_drain(10);

    // Saturation
    drive(30'h3FFFFFFF, 1, 0, 1, 0, 0, 0, 1);
    measure_latency(lat);
    check("lat_sat", lat, 36);
    check("pt_sat", o_point, 16'h7FFF);
    wait_drain(10);

    // Mixed ordered batch
    drive(5000, 37, 2047, 1, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 1);
    drive(777, 0, 3, 1, 0, 0, 0, 1);
    drive(123456, 999, 100, 1, 1, 1, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 0, 1);
    idle();
    wait_drain(400);
    check("ovf_clear_batch", o_overflow, 0);

    // Backpressure for 10 cycles during OUT
    ready = 1'b0;
    drive(4000, 250, 7, 1, 1, 0, 0, 1);
    idle();
    wait_valid(100, found);
    check("bp_found", found, 1);
    b0 = n_beats;
    repeat (10) @(negedge clk);
    @(posedge clk); #1 ready = 1'b1;
    wait_drain(20);
    repeat (5) @(negedge clk);
    check("bp_one_beat", n_beats - b0, 1);

    // Overflow: 20 entries while stalled, 17 survive
    ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      drive(30'(1000 + i * 37), 23'(10 + i), 11'(i), 1, 0, 0, 0, i <= 17);
    end
    idle();
    repeat (60) @(negedge clk);
    check("ovf_set", o_overflow, 1);
    @(posedge clk); #1 ready = 1'b1;
    wait_drain(17 * 45);
    check("ovf_sticky", o_overflow, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    @(negedge clk);
    check("ovf_nf_clear", o_overflow, 0);
    wait_drain(20);

    // Reset while a beat is held in OUT
    ready = 1'b0;
    drive(300, 100, 50, 1, 0, 0, 0, 1);
    idle();
    wait_valid(100, found);
    check("out_found", found, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_out_valid", o_valid, 0);
    check("rst_out_point", o_point, 0);
    check("rst_out_pv", o_point_valid, 0);
    @(negedge clk) begin rst_n = 1'b1; ready = 1'b1; end
    repeat (2) @(negedge clk);

    // Reset in division step 20 with three entries buffered
    drive(300, 100, 50, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(55, 0, 4, 1, 0, 0, 0, 0);
    drive(900, 30, 9, 1, 0, 1, 0, 0);
    idle();
    repeat (18) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_div_valid", o_valid, 0);
    check("rst_div_point", o_point, 0);
    check("rst_div_ovf", o_overflow, 0);
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (o_valid) cnt++;
    end
    check("rst_no_beats", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cog_divider.md
COG_DIVIDER -- requirements
Module: cog_divider

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, entry count of the input buffer (power of two, >= 4).
REQ-002 Parameter FRAC_BITS, fixed 4, fractional bits of the output coordinate.
REQ-003 i_sys_clk  in  1  single clock; one clock, all logic on its rising edge.
REQ-004 i_sys_aresetn  in  1  reset; asynchronous, active-low.
REQ-005 i_sum_of_I_mult_coord  in  30  sum of I^2 * relative coordinate for a figure.
REQ-006 i_sum_of_I  in  23  sum of I^2 for a figure.
REQ-007 i_start_point  in  11  absolute coordinate of the figure's first pixel.
REQ-008 i_point_is_valid  in  1  one-cycle strobe; the three sums/start are valid this cycle.
REQ-009 i_end_of_line, i_end_of_frame, i_new_frame  in  1 each  delayed markers, already aligned with the point strobe.
REQ-010 o_point  out  16  absolute CoG coordinate, unsigned 12.4 fixed point.
REQ-011 o_point_valid  out  1  o_point carries a result in this beat.
REQ-012 o_end_of_line, o_end_of_frame, o_new_frame  out  1 each  markers carried in this beat.
REQ-013 o_valid  out  1  beat present; i_ready  in  1  downstream accepts the beat.
REQ-014 o_overflow  out  1  sticky flag, input entry lost.

Function
REQ-015 Input capture: in any cycle where i_point_is_valid or any marker is 1, one entry {point flag, 3 markers, sums, start} SHALL be written to the FIFO; all-zero cycles write nothing.
REQ-016 Point and markers in the same cycle SHALL share one entry; the point is processed first and the markers are emitted in the same beat.
REQ-017 FIFO full and no pop in that cycle: the entry SHALL be dropped and o_overflow set; full with a simultaneous pop: the write SHALL be accepted.
REQ-018 o_overflow SHALL clear only on reset or on a written entry with i_new_frame = 1, where the clear takes priority over a same-cycle set.
REQ-019 FSM states IDLE, DIV, OUT; reset state IDLE.
REQ-020 IDLE: if FIFO is non-empty, pop into working registers; next state is DIV if point flag = 1 and sum_of_I != 0, else OUT.
REQ-021 DIV: restoring radix-2 division of dividend {sum_of_I_mult_coord, 4'b0} (34 bit) by sum_of_I (23 bit), one quotient bit per cycle, exactly 34 cycles, then OUT.
REQ-022 Quotient SHALL saturate to 15'h7FFF when any bit above bit 14 is set.
REQ-023 o_point SHALL equal {i_start_point, 4'b0} + quotient[14:0], 16-bit unsigned, no overflow possible.
REQ-024 A point entry with sum_of_I = 0 SHALL produce a beat with o_point_valid = 0, o_point = 0 and the entry's markers; if no markers are set, the beat is still emitted.
REQ-025 A marker-only entry SHALL produce a beat with o_point_valid = 0 and o_point = 0.
REQ-026 OUT: o_valid = 1 with all outputs held stable until i_ready = 1 on a clock edge; then IDLE, and o_valid drops next cycle.
REQ-027 Latency, from an empty FIFO and IDLE, with input in cycle 0: o_valid rises in cycle 36 for a divided point and in cycle 2 for other entries.
REQ-028 Beats SHALL leave in input order; no reordering or merging of entries.

Reset
REQ-029 Asserting i_sys_aresetn low SHALL immediately clear the FIFO pointers/count, force IDLE, and drive o_valid, o_point_valid, all markers, o_point and o_overflow to 0.
REQ-030 Reset mid-division or mid-OUT SHALL discard the in-flight and buffered entries without emitting a beat after reset release.

Verification
REQ-031 sum_mult=300, sum_I=100, start=50, valid, i_ready=1 -> cycle 36: o_valid=1, o_point_valid=1, o_point=16'd848 (0x350).
REQ-032 valid with sum_I=0, start=10, i_end_of_line=1 -> cycle 2: o_valid=1, o_point_valid=0, o_point=0, o_end_of_line=1.
REQ-033 Saturation case: sum_mult=30'h3FFFFFFF, sum_I=1, start=0 -> o_point=16'h7FFF.
REQ-034 20 consecutive point entries with i_ready=0, then i_ready=1 -> entries 1..17 are emitted in order, 18..20 are lost, and o_overflow=1; a later i_new_frame entry clears it.
REQ-035 Backpressure: hold i_ready=0 for 10 cycles during OUT -> o_point and markers are unchanged for all 10 cycles, and exactly one beat is transferred.
REQ-036 Reset asserted in DIV cycle 20 with 3 entries buffered -> outputs are 0 immediately, and no beat appears within 100 cycles after release.
